// File: rtl/vx_fp_round_pipe_pkg.sv
// Shared FPU encodings for the rounding pipe: rounding-mode values,
// fflags bit positions and the rounding-mode legality helper.
package vx_fp_round_pipe_pkg;

    localparam logic [2:0] INST_FRM_RNE = 3'b000;
    localparam logic [2:0] INST_FRM_RTZ = 3'b001;
    localparam logic [2:0] INST_FRM_RDN = 3'b010;
    localparam logic [2:0] INST_FRM_RUP = 3'b011;
    localparam logic [2:0] INST_FRM_RMM = 3'b100;
    localparam logic [2:0] INST_FRM_DYN = 3'b111;

    localparam int FFLAG_NX   = 0;
    localparam int FFLAG_UF   = 1;
    localparam int FFLAG_OF   = 2;
    localparam int FFLAG_DZ   = 3;
    localparam int FFLAG_NV   = 4;
    localparam int FFLAG_BITS = 5;

    // RNE..RMM are the only encodings a resolved mode may take.
    function automatic logic is_valid_frm(input logic [2:0] frm);
        return (frm <= INST_FRM_RMM);
    endfunction

endpackage

// File: rtl/vx_fp_round_lane.sv
// Combinational per-lane rounding. The decide half picks round_up from the
// resolved mode; the apply half adds it and derives sign, exact-zero and
// per-lane flags. The two halves may be fed from different pipeline stages.
module vx_fp_round_lane
    import vx_fp_round_pipe_pkg::*;
#(
    parameter int EXP_BITS = 8,
    parameter int MAN_BITS = 23
) (
    input  logic [2:0]                   i_dec_mode,
    input  logic                         i_dec_mode_ok,
    input  logic                         i_dec_sign,
    input  logic [1:0]                   i_dec_rs,
    input  logic                         i_dec_lsb,
    output logic                         o_round_up,
    input  logic [2:0]                   i_mode,
    input  logic [EXP_BITS+MAN_BITS-1:0] i_abs,
    input  logic                         i_round_up,
    input  logic                         i_sign,
    input  logic [1:0]                   i_rs,
    input  logic                         i_eff_sub,
    output logic [EXP_BITS+MAN_BITS:0]   o_result,
    output logic                         o_exact_zero,
    output logic                         o_of,
    output logic                         o_uf,
    output logic                         o_nx
);

    localparam int ABS_W = EXP_BITS + MAN_BITS;

    logic [ABS_W-1:0]    w_sum;
    logic [EXP_BITS-1:0] w_exp_in;
    logic [EXP_BITS-1:0] w_exp_out;
    logic                w_zero;
    logic                w_sign;
    logic                w_of;
    logic                w_nx;

    // Round-up decision; an illegal mode never rounds.
    always_comb begin
        o_round_up = 1'b0;
        if (i_dec_mode_ok) begin
            case (i_dec_mode)
                INST_FRM_RNE: o_round_up = (i_dec_rs == 2'b11) | ((i_dec_rs == 2'b10) & i_dec_lsb);
                INST_FRM_RTZ: o_round_up = 1'b0;
                INST_FRM_RDN: o_round_up = (|i_dec_rs) & i_dec_sign;
                INST_FRM_RUP: o_round_up = (|i_dec_rs) & ~i_dec_sign;
                INST_FRM_RMM: o_round_up = i_dec_rs[1];
                default:      o_round_up = 1'b0;
            endcase
        end
    end

    // Increment lets a mantissa carry ripple into the exponent field.
    always_comb begin
        w_sum        = i_abs + ABS_W'(i_round_up);
        w_exp_in     = i_abs[ABS_W-1 -: EXP_BITS];
        w_exp_out    = w_sum[ABS_W-1 -: EXP_BITS];
        w_of         = (&w_exp_out) & ~(&w_exp_in);
        w_nx         = (|i_rs) | w_of;
        w_zero       = (i_abs == '0) && (i_rs == 2'b00);
        w_sign       = (w_zero && i_eff_sub) ? (i_mode == INST_FRM_RDN) : i_sign;
        o_result     = {w_sign, w_sum};
        o_exact_zero = w_zero;
        o_of         = w_of;
        o_nx         = w_nx;
        o_uf         = (w_exp_out == '0) && w_nx;
    end

endmodule

// File: rtl/vx_fp_round_pipe.sv
// Multi-lane pipelined rounding stage. Resolves DYN against frm, rounds
// every lane, reduces fflags over active lanes, and moves requests with a
// single global stall enable.
module vx_fp_round_pipe
    import vx_fp_round_pipe_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int EXP_BITS  = 8,
    parameter int MAN_BITS  = 23,
    parameter int LATENCY   = 2,
    parameter int TAG_WIDTH = 8
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    valid_in,
    output logic                                    ready_in,
    input  logic [TAG_WIDTH-1:0]                    tag_in,
    input  logic [NUM_LANES-1:0]                    lane_mask_in,
    input  logic [2:0]                              rnd_mode_in,
    input  logic [2:0]                              frm_in,
    input  logic [NUM_LANES*(EXP_BITS+MAN_BITS)-1:0] abs_value_in,
    input  logic [NUM_LANES-1:0]                    sign_in,
    input  logic [NUM_LANES*2-1:0]                  round_sticky_in,
    input  logic [NUM_LANES-1:0]                    eff_sub_in,
    output logic                                    valid_out,
    input  logic                                    ready_out,
    output logic [TAG_WIDTH-1:0]                    tag_out,
    output logic [NUM_LANES-1:0]                    lane_mask_out,
    output logic [NUM_LANES*(EXP_BITS+MAN_BITS+1)-1:0] result_out,
    output logic [NUM_LANES-1:0]                    exact_zero_out,
    output logic [FFLAG_BITS-1:0]                   fflags_out
);

    localparam int DATA_WIDTH = EXP_BITS + MAN_BITS + 1;
    localparam int ABS_W      = DATA_WIDTH - 1;

    logic                            w_en;
    logic [2:0]                      w_eff;
    logic                            w_mode_ok;
    logic [NUM_LANES-1:0]            w_round_up;

    logic                            w_s1_valid;
    logic [TAG_WIDTH-1:0]            w_s1_tag;
    logic [NUM_LANES-1:0]            w_s1_mask;
    logic [2:0]                      w_s1_eff;
    logic                            w_s1_mode_ok;
    logic [NUM_LANES*ABS_W-1:0]      w_s1_abs;
    logic [NUM_LANES-1:0]            w_s1_sign;
    logic [NUM_LANES*2-1:0]          w_s1_rs;
    logic [NUM_LANES-1:0]            w_s1_eff_sub;
    logic [NUM_LANES-1:0]            w_s1_round_up;

    logic [NUM_LANES*DATA_WIDTH-1:0] w_lane_res;
    logic [NUM_LANES-1:0]            w_lane_zero;
    logic [NUM_LANES-1:0]            w_lane_of;
    logic [NUM_LANES-1:0]            w_lane_uf;
    logic [NUM_LANES-1:0]            w_lane_nx;

    logic [NUM_LANES*DATA_WIDTH-1:0] w_res;
    logic [NUM_LANES-1:0]            w_zero;
    logic [FFLAG_BITS-1:0]           w_fflags;

    assign w_en      = ~(valid_out & ~ready_out);
    assign ready_in  = w_en;
    assign w_eff     = (rnd_mode_in == INST_FRM_DYN) ? frm_in : rnd_mode_in;
    assign w_mode_ok = is_valid_frm(w_eff);

    generate
        if (LATENCY == 2) begin : g_stage1
            logic                       r_valid;
            logic [TAG_WIDTH-1:0]       r_tag;
            logic [NUM_LANES-1:0]       r_mask;
            logic [2:0]                 r_eff;
            logic                       r_mode_ok;
            logic [NUM_LANES*ABS_W-1:0] r_abs;
            logic [NUM_LANES-1:0]       r_sign;
            logic [NUM_LANES*2-1:0]     r_rs;
            logic [NUM_LANES-1:0]       r_eff_sub;
            logic [NUM_LANES-1:0]       r_round_up;

            // First stage captures the resolved mode, round decisions and raw operands.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_valid    <= 1'b0;
                    r_tag      <= '0;
                    r_mask     <= '0;
                    r_eff      <= '0;
                    r_mode_ok  <= 1'b0;
                    r_abs      <= '0;
                    r_sign     <= '0;
                    r_rs       <= '0;
                    r_eff_sub  <= '0;
                    r_round_up <= '0;
                end else if (w_en) begin
                    r_valid    <= valid_in;
                    r_tag      <= tag_in;
                    r_mask     <= lane_mask_in;
                    r_eff      <= w_eff;
                    r_mode_ok  <= w_mode_ok;
                    r_abs      <= abs_value_in;
                    r_sign     <= sign_in;
                    r_rs       <= round_sticky_in;
                    r_eff_sub  <= eff_sub_in;
                    r_round_up <= w_round_up;
                end
            end

            assign w_s1_valid    = r_valid;
            assign w_s1_tag      = r_tag;
            assign w_s1_mask     = r_mask;
            assign w_s1_eff      = r_eff;
            assign w_s1_mode_ok  = r_mode_ok;
            assign w_s1_abs      = r_abs;
            assign w_s1_sign     = r_sign;
            assign w_s1_rs       = r_rs;
            assign w_s1_eff_sub  = r_eff_sub;
            assign w_s1_round_up = r_round_up;
        end else if (LATENCY == 1) begin : g_bypass
            assign w_s1_valid    = valid_in;
            assign w_s1_tag      = tag_in;
            assign w_s1_mask     = lane_mask_in;
            assign w_s1_eff      = w_eff;
            assign w_s1_mode_ok  = w_mode_ok;
            assign w_s1_abs      = abs_value_in;
            assign w_s1_sign     = sign_in;
            assign w_s1_rs       = round_sticky_in;
            assign w_s1_eff_sub  = eff_sub_in;
            assign w_s1_round_up = w_round_up;
        end else begin : g_bad_latency
            $error("vx_fp_round_pipe: LATENCY must be 1 or 2");
        end
    endgenerate

    generate
        for (genvar gl = 0; gl < NUM_LANES; gl++) begin : g_lane
            vx_fp_round_lane #(
                .EXP_BITS (EXP_BITS),
                .MAN_BITS (MAN_BITS)
            ) u_lane (
                .i_dec_mode    (w_eff),
                .i_dec_mode_ok (w_mode_ok),
                .i_dec_sign    (sign_in[gl]),
                .i_dec_rs      (round_sticky_in[gl*2 +: 2]),
                .i_dec_lsb     (abs_value_in[gl*ABS_W]),
                .o_round_up    (w_round_up[gl]),
                .i_mode        (w_s1_eff),
                .i_abs         (w_s1_abs[gl*ABS_W +: ABS_W]),
                .i_round_up    (w_s1_round_up[gl]),
                .i_sign        (w_s1_sign[gl]),
                .i_rs          (w_s1_rs[gl*2 +: 2]),
                .i_eff_sub     (w_s1_eff_sub[gl]),
                .o_result      (w_lane_res[gl*DATA_WIDTH +: DATA_WIDTH]),
                .o_exact_zero  (w_lane_zero[gl]),
                .o_of          (w_lane_of[gl]),
                .o_uf          (w_lane_uf[gl]),
                .o_nx          (w_lane_nx[gl])
            );
        end
    endgenerate

    // Masked lanes contribute nothing; NV marks an illegal resolved mode.
    always_comb begin
        w_res    = '0;
        w_zero   = '0;
        w_fflags = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (w_s1_mask[l]) begin
                w_res[l*DATA_WIDTH +: DATA_WIDTH] = w_lane_res[l*DATA_WIDTH +: DATA_WIDTH];
                w_zero[l]          = w_lane_zero[l];
                w_fflags[FFLAG_OF] = w_fflags[FFLAG_OF] | w_lane_of[l];
                w_fflags[FFLAG_UF] = w_fflags[FFLAG_UF] | w_lane_uf[l];
                w_fflags[FFLAG_NX] = w_fflags[FFLAG_NX] | w_lane_nx[l];
            end
        end
        w_fflags[FFLAG_DZ] = 1'b0;
        w_fflags[FFLAG_NV] = ~w_s1_mode_ok;
    end

    // Output register; holds everything while downstream stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out      <= 1'b0;
            tag_out        <= '0;
            lane_mask_out  <= '0;
            result_out     <= '0;
            exact_zero_out <= '0;
            fflags_out     <= '0;
        end else if (w_en) begin
            valid_out      <= w_s1_valid;
            tag_out        <= w_s1_tag;
            lane_mask_out  <= w_s1_mask;
            result_out     <= w_res;
            exact_zero_out <= w_zero;
            fflags_out     <= w_fflags;
        end
    end

endmodule

// File: doc/vx_fp_round_pipe.md
Name: vx_fp_round_pipe

Overview:
Multi-lane, pipelined IEEE-754 rounding stage for the FPU back end. It rounds NUM_LANES pre-normalised magnitudes per request and resolves the dynamic rounding mode against the CSR frm. It produces RISC-V fflags (NV, OF, UF, NX), aggregated over active lanes, and moves data under valid/ready flow control. It sits between the normaliser of the FMA/ADD/CVT datapaths and the FPU result arbiter.

Parameters:
NUM_LANES, 4, SIMD lanes per request
EXP_BITS, 8, exponent field width
MAN_BITS, 23, mantissa field width; DATA_WIDTH = EXP_BITS+MAN_BITS+1 is derived, not a parameter
LATENCY, 2, pipeline stages, legal values 1 or 2 (elaboration error otherwise)
TAG_WIDTH, 8, opaque request tag carried alongside the data

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
valid_in  in  1  request valid
ready_in  out  1  request accepted when valid_in & ready_in
tag_in  in  TAG_WIDTH  request tag
lane_mask_in  in  NUM_LANES  active lanes
rnd_mode_in  in  3  instruction rm field; 111 = DYN
frm_in  in  3  CSR frm, used when rnd_mode_in==111
abs_value_in  in  NUM_LANES*(DATA_WIDTH-1)  per-lane {exp,man}, truncated
sign_in  in  NUM_LANES  per-lane sign
round_sticky_in  in  NUM_LANES*2  per-lane {round,sticky}
eff_sub_in  in  NUM_LANES  per-lane effective subtraction
valid_out  out  1  result valid
ready_out  in  1  downstream ready
tag_out  out  TAG_WIDTH  tag of the result
lane_mask_out  out  NUM_LANES  mask of the result
result_out  out  NUM_LANES*DATA_WIDTH  per-lane {sign,exp,man}
exact_zero_out  out  NUM_LANES  per-lane true zero
fflags_out  out  5  {NV,DZ,OF,UF,NX}, OR over active lanes

Behaviour:
- Reset (reset==0, asynchronous): all pipeline valid bits and every output register clear to 0, so valid_out=0, result_out=0, fflags_out=0 and tag_out=0. ready_in follows the combinational equation below.
- Mode resolution: eff = (rnd_mode_in==3'b111) ? frm_in : rnd_mode_in. If eff is 101, 110 or 111, the request is invalid:
  - round_up=0 on all lanes;
  - fflags NV=1;
  - the result is otherwise passed through.
- round_up per lane:
  - RNE: rs=10 → LSB of the magnitude; rs=11 → 1; otherwise 0.
  - RTZ: 0.
  - RDN: |rs & sign.
  - RUP: |rs & ~sign.
  - RMM: rs[1].
- Magnitude: abs_value + round_up, computed at DATA_WIDTH-1 width. A mantissa carry propagates into the exponent field by design.
- Exact zero: abs_value==0 && rs==0.
  - If exact zero & eff_sub, the output sign is (eff==RDN).
  - Otherwise the output sign is sign_in.
- Per-lane flags:
  - OF: rounded exp==all-ones && input exp!=all-ones.
  - NX: |rs | OF.
  - UF: rounded exp==0 && NX (tininess detected after rounding).
  - DZ: always 0.
- fflags_out: OR of the per-lane flags over lanes with lane_mask==1, plus NV. Masked lanes output result=0 and exact_zero=0.
- Pipeline:
  - LATENCY=2: stage 1 registers eff, round_up, the inputs and the tag; stage 2 registers the sum, sign and flags.
  - LATENCY=1: all work is done before a single register.
  - Latency is exactly LATENCY cycles from acceptance to valid_out when ready_out=1.
- Flow control:
  - Global enable en = ~(valid_out & ~ready_out). ready_in = en. All stages advance on en.
  - Bubbles are not collapsed.
  - While stalled, every output holds stable. No request is dropped or duplicated, and order is preserved.
- Simultaneous accept and drain with ready_out=1 sustains one request per cycle.
- Reset mid-flight discards all in-flight requests.

Decomposition:
- Shared package (VX_fpu_pkg / VX_define.vh): INST_FRM_* encodings including DYN=3'b111, fflag bit indices, and the is_valid_frm helper.
- One sub-module: vx_fp_round_lane, the combinational per-lane round, sign, exact-zero and flag logic. It is instantiated NUM_LANES times by a generate loop. The top level owns mode resolution, flag reduction and the pipeline registers.

Test Plan:
1. RNE, default parameters, lane 0:
   - abs=0x3F800001, rs=10 → result 0x3F800002, NX=1.
   - abs=0x3F800000, rs=10 → 0x3F800000, fflags=5'b00001.
2. DYN: rnd_mode=111, frm=011, sign=0, abs=0x3F800000, rs=01 → 0x3F800001, NX. Same request with frm=101 → 0x3F800000, NV=1.
3. Overflow: RNE, abs=0x7F7FFFFF, rs=11 → 0x7F800000, fflags=5'b00101. Subnormal case: abs=0x00000000, rs=01, RUP → 0x00000001, fflags=5'b00011.
4. Exact zero with eff_sub=1, sign=0, abs=0, rs=00: RDN → 0x80000000 with exact_zero=1; RNE → 0x00000000. With lane_mask=4'b0101, overflow stimulus on lanes 1 and 3 → fflags_out=0.
5. Backpressure: issue 3 back-to-back requests with tags 1, 2, 3 and hold ready_out=0 for 4 cycles.
   - ready_in=0 once the pipe is full.
   - Outputs are held stable.
   - After release, tags emerge 1, 2, 3 on consecutive cycles.
6. Reset mid-flight: drop reset while 2 requests are in flight → valid_out=0 and fflags_out=0 immediately (asynchronous), with no stale output after release.
